// File: rtl/apa102_strip_rx_if.sv
// Strip pins and pixel output bus for apa102_strip_rx.
// APA102_RX_FB_EN adds the fb_out framebuffer vector.
interface apa102_strip_rx_if #(
  parameter int unsigned IDX_W = 6
`ifdef APA102_RX_FB_EN
  ,
  parameter int unsigned NUM_LEDS = 64
`endif
);
  logic             sclk_in;
  logic             sdata_in;
  logic             pix_valid;
  logic [IDX_W-1:0] pix_index;
  logic [4:0]       pix_bright;
  logic [7:0]       pix_blue;
  logic [7:0]       pix_green;
  logic [7:0]       pix_red;
  logic             frame_done;
  logic             frame_err;
  logic             busy;
`ifdef APA102_RX_FB_EN
  logic [NUM_LEDS-1:0] fb_out;
`endif

  modport master (
    input  sclk_in,
    input  sdata_in,
    output pix_valid,
    output pix_index,
    output pix_bright,
    output pix_blue,
    output pix_green,
    output pix_red,
    output frame_done,
    output frame_err,
`ifdef APA102_RX_FB_EN
    output fb_out,
`endif
    output busy
  );

  modport slave (
    output sclk_in,
    output sdata_in,
    input  pix_valid,
    input  pix_index,
    input  pix_bright,
    input  pix_blue,
    input  pix_green,
    input  pix_red,
    input  frame_done,
    input  frame_err,
`ifdef APA102_RX_FB_EN
    input  fb_out,
`endif
    input  busy
  );
endinterface

// File: rtl/apa102_strip_rx.sv
// APA102 two-wire stream receiver: oversamples sclk, emits one strobe per LED word.
// Define APA102_RX_FB_EN to add the one-bit-per-LED framebuffer output fb_out.
module apa102_strip_rx #(
  parameter int unsigned NUM_LEDS    = 64,
  parameter int unsigned IDX_W       = 6,
  parameter int unsigned TIMEOUT_CYC = 4096
`ifdef APA102_RX_FB_EN
  ,
  parameter logic [31:0] FG_COLOUR   = 32'hf0000f00
`endif
) (
  input logic               clk,
  input logic               reset,
  apa102_strip_rx_if.master bus
);

  localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_LED = IDX_W'(NUM_LEDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {StSync, StData} state_e;

  state_e           state_q;
  logic             sclk_s1, sclk_s2, sclk_s3;
  logic             sdata_s1, sdata_s2;
  logic             sclk_fall, sclk_edge;
  logic [5:0]       zero_cnt_q;
  logic [5:0]       bit_cnt_q;
  logic [IDX_W-1:0] led_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [31:0]      shift_q;
  logic [31:0]      word_q;
  logic             pend_q;

  // Equal-depth synchronizers keep data aligned with the detected clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      sclk_s1  <= bus.sclk_in;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      sdata_s1 <= bus.sdata_in;
      sdata_s2 <= sdata_s1;
    end
  end

  assign sclk_fall = sclk_s3 & ~sclk_s2;
  assign sclk_edge = sclk_s3 ^ sclk_s2;

`ifdef APA102_RX_FB_EN
  logic [NUM_LEDS-1:0] fb_shadow_q;
  logic [NUM_LEDS-1:0] fb_next;

  always_comb begin
    fb_next            = fb_shadow_q;
    fb_next[led_cnt_q] = (word_q == FG_COLOUR);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StSync;
      zero_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      led_cnt_q      <= '0;
      to_cnt_q       <= '0;
      shift_q        <= '0;
      word_q         <= '0;
      pend_q         <= 1'b0;
      bus.pix_valid  <= 1'b0;
      bus.pix_index  <= '0;
      bus.pix_bright <= '0;
      bus.pix_blue   <= '0;
      bus.pix_green  <= '0;
      bus.pix_red    <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
`ifdef APA102_RX_FB_EN
      fb_shadow_q    <= '0;
      bus.fb_out     <= '0;
`endif
    end else begin
      bus.pix_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      pend_q         <= 1'b0;
      case (state_q)
        StSync: begin
          to_cnt_q <= '0;
          if (sclk_fall) begin
            if (!sdata_s2) begin
              if (zero_cnt_q != 6'd32) zero_cnt_q <= zero_cnt_q + 6'd1;
            end else if (zero_cnt_q == 6'd32) begin
              // This 1 is bit 31 of LED 0.
              state_q    <= StData;
              bus.busy   <= 1'b1;
              shift_q    <= 32'd1;
              bit_cnt_q  <= 6'd1;
              led_cnt_q  <= '0;
              zero_cnt_q <= '0;
            end else begin
              zero_cnt_q <= '0;
            end
          end
        end
        StData: begin
          if (sclk_edge) to_cnt_q <= '0;
          else           to_cnt_q <= to_cnt_q + 1'b1;
          if (sclk_fall) begin
            shift_q <= {shift_q[30:0], sdata_s2};
            if (bit_cnt_q == 6'd31) begin
              word_q    <= {shift_q[30:0], sdata_s2};
              pend_q    <= 1'b1;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
          if (pend_q) begin
            if (word_q[31:29] == 3'b111) begin
              bus.pix_valid  <= 1'b1;
              bus.pix_index  <= led_cnt_q;
              bus.pix_bright <= word_q[28:24];
              bus.pix_blue   <= word_q[23:16];
              bus.pix_green  <= word_q[15:8];
              bus.pix_red    <= word_q[7:0];
`ifdef APA102_RX_FB_EN
              fb_shadow_q    <= fb_next;
`endif
              if (led_cnt_q == LAST_LED) begin
                bus.frame_done <= 1'b1;
                led_cnt_q      <= '0;
                zero_cnt_q     <= '0;
                state_q        <= StSync;
                bus.busy       <= 1'b0;
`ifdef APA102_RX_FB_EN
                bus.fb_out     <= fb_next;
`endif
              end else begin
                led_cnt_q <= led_cnt_q + 1'b1;
              end
            end else begin
              bus.frame_err <= 1'b1;
              led_cnt_q     <= '0;
              zero_cnt_q    <= '0;
              state_q       <= StSync;
              bus.busy      <= 1'b0;
            end
          end else if (!sclk_edge && to_cnt_q == TO_LAST) begin
            // A coincident edge keeps the frame alive.
            bus.frame_err <= 1'b1;
            led_cnt_q     <= '0;
            zero_cnt_q    <= '0;
            state_q       <= StSync;
            bus.busy      <= 1'b0;
          end
        end
        default: begin
          state_q  <= StSync;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apa102_strip_rx.sv
// Randomized bench for apa102_strip_rx; expectations come from the word lists each test sends.
module tb_apa102_strip_rx;
  localparam int unsigned NUM_LEDS    = 64;
  localparam int unsigned TIMEOUT_CYC = 4096;
  localparam logic [31:0] FG          = 32'hf0000f00;

  typedef struct packed {
    logic [5:0] idx;
    logic [4:0] bright;
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
    logic       done;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  apa102_strip_rx_if bus ();

  apa102_strip_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pix_t obs_q[$];
  int   err_cnt, done_cnt, stretch_cnt;
  logic prev_v = 1'b0, prev_d = 1'b0, prev_e = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(negedge clk) begin
    if (bus.pix_valid)
      obs_q.push_back('{idx: bus.pix_index, bright: bus.pix_bright, blue: bus.pix_blue,
                        green: bus.pix_green, red: bus.pix_red, done: bus.frame_done});
    if (bus.frame_err) err_cnt++;
    if (bus.frame_done) done_cnt++;
    if ((bus.pix_valid && prev_v) || (bus.frame_done && prev_d) || (bus.frame_err && prev_e))
      stretch_cnt++;
    prev_v = bus.pix_valid;
    prev_d = bus.frame_done;
    prev_e = bus.frame_err;
  end

  function automatic pix_t exp_pix(input int i, input logic [31:0] w);
    return '{idx: 6'(i), bright: w[28:24], blue: w[23:16], green: w[15:8], red: w[7:0],
             done: (i == NUM_LEDS - 1)};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    if ($urandom_range(0, 3) == 0) return FG;
    w        = $urandom();
    w[31:29] = 3'b111;
    return w;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Data changes with the rising strip clock; the receiver samples on the falling one.
  task automatic send_bit(input logic b);
    bus.sdata_in = b;
    bus.sclk_in  = 1'b1;
    wait_clk($urandom_range(2, 3));
    bus.sclk_in  = 1'b0;
    wait_clk($urandom_range(2, 3));
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    err_cnt     = 0;
    done_cnt    = 0;
    stretch_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.sclk_in  = 1'b0;
    bus.sdata_in = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic test_single();
    pix_t got;
    do_reset();
    send_zeros(32);
    send_word(FG);
    wait_clk(12);
    n_checks++;
    if (obs_q.size() !== 1) $display("FAIL single_count: got %0d want 1", obs_q.size());
    else n_pass++;
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    n_checks++;
    if (got !== pix_t'({6'd0, 5'h10, 8'h00, 8'h0f, 8'h00, 1'b0}))
      $display("FAIL single_fields: got %h want %h", got,
               pix_t'({6'd0, 5'h10, 8'h00, 8'h0f, 8'h00, 1'b0}));
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b1 || err_cnt !== 0)
      $display("FAIL single_state: busy %b err %0d want busy 1 err 0", bus.busy, err_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    // Follows test_single, so fields and busy are non-zero going in.
    do_reset();
    n_checks++;
    if ({bus.pix_valid, bus.frame_done, bus.frame_err, bus.busy} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000",
               {bus.pix_valid, bus.frame_done, bus.frame_err, bus.busy});
    else n_pass++;
    n_checks++;
    if ({bus.pix_index, bus.pix_bright, bus.pix_blue, bus.pix_green, bus.pix_red} !== '0)
      $display("FAIL reset_fields: got %h want 0",
               {bus.pix_index, bus.pix_bright, bus.pix_blue, bus.pix_green, bus.pix_red});
    else n_pass++;
`ifdef APA102_RX_FB_EN
    n_checks++;
    if (bus.fb_out !== '0) $display("FAIL reset_fb: got %h want 0", bus.fb_out);
    else n_pass++;
`endif
  endtask

  task automatic test_full_refresh();
    logic [31:0] words [NUM_LEDS];
    logic [63:0] exp_fb;
    int          bad;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        words[i]  = rand_word();
        exp_fb[i] = (words[i] == FG);
      end
      clear_obs();
      send_zeros(32);
      for (int i = 0; i < NUM_LEDS; i++) send_word(words[i]);
      send_zeros(64);
      wait_clk(8);
      n_checks++;
      if (obs_q.size() !== NUM_LEDS)
        $display("FAIL refresh%0d_count: got %0d want %0d", r, obs_q.size(), NUM_LEDS);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < NUM_LEDS && i < obs_q.size(); i++) begin
        if (obs_q[i] !== exp_pix(i, words[i])) begin
          if (bad == 0)
            $display("FAIL refresh%0d_pix%0d: got %h want %h", r, i, obs_q[i],
                     exp_pix(i, words[i]));
          bad++;
        end
      end
      n_checks++;
      if (bad != 0) $display("FAIL refresh%0d_pixels: %0d wrong want 0", r, bad);
      else n_pass++;
      n_checks++;
      if (done_cnt !== 1 || err_cnt !== 0 || stretch_cnt !== 0 || bus.busy !== 1'b0)
        $display("FAIL refresh%0d_pulses: done %0d err %0d stretch %0d busy %b want 1 0 0 0",
                 r, done_cnt, err_cnt, stretch_cnt, bus.busy);
      else n_pass++;
`ifdef APA102_RX_FB_EN
      n_checks++;
      if (bus.fb_out !== exp_fb)
        $display("FAIL refresh%0d_fb: got %h want %h", r, bus.fb_out, exp_fb);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_bad_header();
    logic [31:0] words [NUM_LEDS];
    int          bad;
    do_reset();
    send_zeros(32);
    send_word(32'ha0070000);
    wait_clk(10);
    n_checks++;
    if (err_cnt !== 1 || obs_q.size() !== 0 || bus.busy !== 1'b0)
      $display("FAIL bad_header: err %0d pix %0d busy %b want 1 0 0",
               err_cnt, obs_q.size(), bus.busy);
    else n_pass++;
    clear_obs();
    for (int i = 0; i < NUM_LEDS; i++) words[i] = rand_word();
    send_zeros(32);
    for (int i = 0; i < NUM_LEDS; i++) send_word(words[i]);
    send_zeros(32);
    wait_clk(8);
    bad = (obs_q.size() == NUM_LEDS) ? 0 : 1;
    for (int i = 0; i < NUM_LEDS && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_pix(i, words[i])) bad++;
    n_checks++;
    if (bad != 0 || done_cnt !== 1 || err_cnt !== 0)
      $display("FAIL after_bad_refresh: wrong %0d pix %0d done %0d err %0d want 0 64 1 0",
               bad, obs_q.size(), done_cnt, err_cnt);
    else n_pass++;
  endtask

  task automatic test_short_start();
    do_reset();
    send_zeros(31);
    send_word(32'hf0070000);
    wait_clk(10);
    n_checks++;
    if (obs_q.size() !== 0 || bus.busy !== 1'b0 || err_cnt !== 0)
      $display("FAIL short_start: pix %0d busy %b err %0d want 0 0 0",
               obs_q.size(), bus.busy, err_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [6:0] tail;
    do_reset();
    tail = 7'($urandom());
    send_zeros(32);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 6; i >= 0; i--) send_bit(tail[i]);
    wait_clk(TIMEOUT_CYC - 50);
    n_checks++;
    if (bus.busy !== 1'b1 || err_cnt !== 0)
      $display("FAIL timeout_early: busy %b err %0d want 1 0", bus.busy, err_cnt);
    else n_pass++;
    wait_clk(100);
    n_checks++;
    if (err_cnt !== 1 || bus.busy !== 1'b0 || done_cnt !== 0 || obs_q.size() !== 0)
      $display("FAIL timeout: err %0d busy %b done %0d pix %0d want 1 0 0 0",
               err_cnt, bus.busy, done_cnt, obs_q.size());
    else n_pass++;
  endtask

`ifdef APA102_RX_FB_EN
  task automatic test_framebuffer();
    do_reset();
    send_zeros(32);
    for (int i = 0; i < NUM_LEDS; i++)
      send_word((i == 0 || i == NUM_LEDS - 1) ? FG : 32'hf0070000);
    send_zeros(8);
    n_checks++;
    if (bus.fb_out !== 64'h8000_0000_0000_0001)
      $display("FAIL fb_frame: got %h want 8000000000000001", bus.fb_out);
    else n_pass++;
    // A timed-out frame must leave the framebuffer alone.
    send_zeros(32);
    send_word(FG);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_clk(TIMEOUT_CYC + 50);
    n_checks++;
    if (bus.fb_out !== 64'h8000_0000_0000_0001 || err_cnt !== 1)
      $display("FAIL fb_timeout: got %h err %0d want 8000000000000001 1", bus.fb_out, err_cnt);
    else n_pass++;
    send_zeros(32);
    for (int i = 0; i < 20; i++) send_word(FG);
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    n_checks++;
    if (bus.fb_out !== 64'h8000_0000_0000_0001 || bus.busy !== 1'b1)
      $display("FAIL fb_mid: got %h busy %b want 8000000000000001 1", bus.fb_out, bus.busy);
    else n_pass++;
    do_reset();
    n_checks++;
    if (bus.fb_out !== '0 || bus.busy !== 1'b0)
      $display("FAIL fb_reset: got %h busy %b want 0 0", bus.fb_out, bus.busy);
    else n_pass++;
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sclk_in  = 1'b0;
    bus.sdata_in = 1'b0;
    test_single();
    test_reset();
    test_full_refresh();
    test_bad_header();
    test_short_start();
    test_timeout();
`ifdef APA102_RX_FB_EN
    test_framebuffer();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
